// File: rtl/comparador_pkg.sv
// Shared definitions for the persistent comparator: compare-mode codes and
// the filter FSM state encoding.
package comparador_pkg;

    localparam logic [2:0] MODE_EQ = 3'd0;
    localparam logic [2:0] MODE_NE = 3'd1;
    localparam logic [2:0] MODE_LT = 3'd2;
    localparam logic [2:0] MODE_LE = 3'd3;
    localparam logic [2:0] MODE_GT = 3'd4;
    localparam logic [2:0] MODE_GE = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        MATCHED = 2'd2
    } state_t;

endpackage

// File: rtl/comparador_modo.sv
// Combinational unsigned relational compare of a against b.
// Ports: a, b (WIDTH-bit operands), mode (3-bit compare mode),
//        match (1 when the relation holds; reserved modes 6/7 never match).
module comparador_modo
    import comparador_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             match
);

    // Relation select
    always_comb begin
        match = 1'b0;
        case (mode)
            MODE_EQ: match = (a == b);
            MODE_NE: match = (a != b);
            MODE_LT: match = (a <  b);
            MODE_LE: match = (a <= b);
            MODE_GT: match = (a >  b);
            MODE_GE: match = (a >= b);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/comparador_persistente.sv
// Streamed sample vs. loadable threshold comparator with a persistence filter.
// result asserts only after `persist` consecutive matching valid samples,
// rise pulses once per assertion, evt_count counts rises (saturating).
// Ports: clk, rst_n (async active-low); in_valid/in sample stream; mode;
//        thr_load/thr_in threshold update; persist; clr_evt;
//        result, rise, evt_count, thr_out (all registered).
module comparador_persistente
    import comparador_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CONST     = 10,
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned EVT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in,
    input  logic [2:0]           mode,
    input  logic                 thr_load,
    input  logic [WIDTH-1:0]     thr_in,
    input  logic [CNT_WIDTH-1:0] persist,
    input  logic                 clr_evt,
    output logic                 result,
    output logic                 rise,
    output logic [EVT_WIDTH-1:0] evt_count,
    output logic [WIDTH-1:0]     thr_out
);

    localparam logic [WIDTH-1:0] THR_RST = WIDTH'(CONST);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   result_d, rise_d;
    logic [EVT_WIDTH-1:0]   evt_d;
    logic                   match_c;
    logic [CNT_WIDTH-1:0]   persist_eff_c;
    logic [CNT_WIDTH-1:0]   cnt_inc_c;

    // Comparison uses the threshold held before any same-cycle load
    comparador_modo #(.WIDTH(WIDTH)) u_modo (
        .a     (in),
        .b     (thr_out),
        .mode  (mode),
        .match (match_c)
    );

    assign persist_eff_c = (persist == '0) ? CNT_WIDTH'(1) : persist;
    assign cnt_inc_c     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result    <= 1'b0;
            rise      <= 1'b0;
            evt_count <= '0;
            thr_out   <= THR_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result    <= result_d;
            rise      <= rise_d;
            evt_count <= evt_d;
            if (thr_load) begin
                thr_out <= thr_in;
            end
        end
    end

    // Next-state, run counter and event counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        evt_d   = evt_count;

        if (in_valid) begin
            if (!match_c) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_inc_c;
                case (state_q)
                    // >= lets a persist reduced mid-run fire on the next match
                    IDLE, ARMING: begin
                        if (cnt_inc_c >= persist_eff_c) begin
                            state_d = MATCHED;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ARMING;
                        end
                    end
                    MATCHED: state_d = MATCHED;
                    default: state_d = IDLE;
                endcase
            end
        end

        result_d = (state_d == MATCHED);

        // Clear wins over a coincident rise
        if (clr_evt) begin
            evt_d = '0;
        end else if (rise_d && (evt_count != '1)) begin
            evt_d = evt_count + EVT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_comparador_persistente.sv
// Scoreboard bench for comparador_persistente: the driver pushes the
// reference model's expected post-edge outputs, a monitor pops and compares.
module tb_comparador_persistente;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_s;
    logic [2:0] mode;
    logic       thr_load;
    logic [3:0] thr_in;
    logic [3:0] persist;
    logic       clr_evt;
    logic       result;
    logic       rise;
    logic [7:0] evt_count;
    logic [3:0] thr_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       res;
        logic       rise;
        logic [7:0] evt;
        logic [3:0] thr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference model state (abstract: run length and previous flag)
    int m_thr, m_run, m_evt;
    bit m_res;

    comparador_persistente #(
        .WIDTH(4), .CONST(10), .CNT_WIDTH(4), .EVT_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in_s),
        .mode      (mode),
        .thr_load  (thr_load),
        .thr_in    (thr_in),
        .persist   (persist),
        .clr_evt   (clr_evt),
        .result    (result),
        .rise      (rise),
        .evt_count (evt_count),
        .thr_out   (thr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_match(input int a, input int b, input int md);
        case (md)
            0: return a == b;
            1: return a != b;
            2: return a <  b;
            3: return a <= b;
            4: return a >  b;
            5: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_thr = 10; m_run = 0; m_evt = 0; m_res = 1'b0;
    endtask

    // Drive one cycle at negedge, step the model, queue the expectation
    task automatic drive(input bit v, input int d, input int md, input int p,
                         input bit ld = 1'b0, input int ti = 0, input bit clr = 1'b0);
        bit rs, nres;
        int pe;
        exp_t e;
        @(negedge clk);
        in_valid = v; in_s = 4'(d); mode = 3'(md); persist = 4'(p);
        thr_load = ld; thr_in = 4'(ti); clr_evt = clr;
        rs = 1'b0;
        if (v) begin
            if (ref_match(d, m_thr, md)) begin
                m_run = (m_run < 15) ? m_run + 1 : 15;
                pe    = (p == 0) ? 1 : p;
                nres  = m_res || (m_run >= pe);
            end else begin
                m_run = 0;
                nres  = 1'b0;
            end
            rs    = nres && !m_res;
            m_res = nres;
        end
        if (clr)                       m_evt = 0;
        else if (rs && m_evt < 255)    m_evt = m_evt + 1;
        if (ld)                        m_thr = ti;
        e.res = m_res; e.rise = rs; e.evt = 8'(m_evt); e.thr = 4'(m_thr);
        q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; thr_load = 1'b0; clr_evt = 1'b0;
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
    endtask

    // Monitor: outputs are presented every edge; compare #1 after it
    always @(posedge clk) begin
        #1;
        if (rst_n && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("result",    int'(result),    int'(mon_e.res));
            chk("rise",      int'(rise),      int'(mon_e.rise));
            chk("evt_count", int'(evt_count), int'(mon_e.evt));
            chk("thr_out",   int'(thr_out),   int'(mon_e.thr));
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_s = '0; mode = '0;
        thr_load = 1'b0; thr_in = '0; persist = 4'd1; clr_evt = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_thr_out", int'(thr_out), 10);
        chk("rst_result",  int'(result),  0);
        chk("rst_rise",    int'(rise),    0);
        chk("rst_evt",     int'(evt_count), 0);

        // EQ, persist=1: immediate match
        drive(1, 10, 0, 1);
        drive(1, 3, 0, 1);

        // GE, persist=3: 11,12 then 9 breaks, 10,10,10 fires at the 6th
        drive(1, 11, 5, 3); drive(1, 12, 5, 3); drive(1, 9, 5, 3);
        drive(1, 10, 5, 3); drive(1, 10, 5, 3); drive(1, 10, 5, 3);
        drive(1, 0, 0, 3);

        // EQ, persist=2 with an invalid gap inside the run
        drive(1, 10, 0, 2); drive(0, 3, 0, 2); drive(1, 10, 0, 2);
        drive(1, 0, 0, 2);

        // Threshold load: same-cycle sample sees the old threshold
        drive(1, 5, 0, 1, 1'b1, 5);
        drive(1, 5, 0, 1);
        drive(1, 0, 0, 1);
        drain();
        chk("thr_after_load", int'(thr_out), 5);

        // Persist lowered while arming
        drive(1, 5, 0, 4); drive(1, 5, 0, 4); drive(1, 5, 0, 1); drive(1, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int d;
            d = ($urandom_range(0, 2) == 0) ? m_thr : int'($urandom_range(0, 15));
            drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 7),
                  $urandom_range(0, 4), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 19) == 0);
        end

        // Event counter saturation
        drive(1, 0, 0, 1, 1'b1, 10, 1'b1);
        for (int i = 0; i < 260; i++) begin
            drive(1, 10, 0, 1);
            drive(1, 0, 0, 1);
        end
        drain();
        chk("evt_saturated", int'(evt_count), 255);
        drive(1, 10, 0, 1, 1'b0, 0, 1'b1);
        drain();
        chk("evt_clr_on_rise", int'(evt_count), 0);

        // Build MATCHED with evt_count=4 on a non-default threshold
        drive(1, 0, 0, 1, 1'b1, 7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 7, 0, 1);
            if (i < 3) drive(1, 0, 0, 1);
        end
        drain();
        chk("pre_rst_result", int'(result), 1);
        chk("pre_rst_evt",    int'(evt_count), 4);
        chk("pre_rst_thr",    int'(thr_out), 7);

        // Async reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_rise",   int'(rise),   0);
        chk("arst_evt",    int'(evt_count), 0);
        chk("arst_thr",    int'(thr_out), 10);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Run resumes from IDLE after reset
        drive(1, 10, 0, 2); drive(1, 10, 0, 2); drive(1, 1, 0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
